// File: rtl/bsg_fifo_reorder_issue_sched.sv
// bsg_fifo_reorder_issue_sched
//
// Shares the allocation port of a bsg_fifo_reorder among num_req_p requesters.
// A round-robin arbiter picks one eligible requester per cycle. The winner
// takes the next free reorder ID, which is tagged with the winner's index and
// presented downstream through a one-entry issue register. When the FIFO
// dequeues its head in order, the owner table steers the response back to the
// requester that allocated that ID. Per-requester credit counters cap the
// number of IDs each requester can hold at once.
//
// Ports:
//   clk_i, reset_n_i         clock; asynchronous active-low reset
//   req_v_i / req_ready_o    per-requester valid / one-hot grant
//   alloc_v_i / alloc_id_i   free ID offered by the reorder FIFO
//   alloc_yumi_o             consume alloc_id_i
//   issue_v_o / issue_id_o / issue_src_o / issue_ready_i
//                            registered tagged request to the engine
//   deq_v_i / deq_id_i       FIFO head ready to dequeue
//   deq_yumi_o               dequeue the FIFO head
//   resp_v_o / resp_src_o / resp_ready_i
//                            response steered to its owning requester
//   idle_o                   no credits outstanding and issue register empty
//
// Optional feature (macro BSG_FIFO_REORDER_ISSUE_SCHED_PERF_EN):
//   stall_cnt_o         cycles with some request pending but no grant
//   credit_block_cnt_o  cycles with a requesting requester at its credit limit
//   Both saturate at all-ones.

module bsg_fifo_reorder_issue_sched #(
  parameter int num_req_p  = 4,
  parameter int els_p      = 8,
  parameter int credits_p  = 4,
  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [num_req_p-1:0] req_v_i,
  output logic [num_req_p-1:0] req_ready_o,
  input  logic                 alloc_v_i,
  input  logic [lg_els_lp-1:0] alloc_id_i,
  output logic                 alloc_yumi_o,
  output logic                 issue_v_o,
  output logic [lg_els_lp-1:0] issue_id_o,
  output logic [lg_req_lp-1:0] issue_src_o,
  input  logic                 issue_ready_i,
  input  logic                 deq_v_i,
  input  logic [lg_els_lp-1:0] deq_id_i,
  output logic                 deq_yumi_o,
  output logic                 resp_v_o,
  output logic [lg_req_lp-1:0] resp_src_o,
  input  logic                 resp_ready_i,
  output logic                 idle_o
`ifdef BSG_FIFO_REORDER_ISSUE_SCHED_PERF_EN
  ,
  output logic [31:0]          stall_cnt_o,
  output logic [31:0]          credit_block_cnt_o
`endif
);

  localparam int cnt_w_lp = $clog2(credits_p + 1);
  localparam logic [cnt_w_lp-1:0] credits_lp = cnt_w_lp'(credits_p);

  logic [cnt_w_lp-1:0]  r_cnt [num_req_p];
  logic [lg_req_lp-1:0] r_owner [els_p];
  logic [lg_req_lp-1:0] r_rr_ptr;
  logic                 r_issue_v;
  logic [lg_els_lp-1:0] r_issue_id;
  logic [lg_req_lp-1:0] r_issue_src;

  logic [num_req_p-1:0] w_elig;
  logic [num_req_p-1:0] w_at_limit;
  logic [num_req_p-1:0] w_inc;
  logic [num_req_p-1:0] w_dec;
  logic [num_req_p-1:0] w_busy;
  logic                 w_found;
  logic [lg_req_lp-1:0] w_gnt_idx;
  logic                 w_grant;

  // Eligibility and rotating-priority search starting at r_rr_ptr.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    int unsigned idx;
    idx       = 0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < num_req_p; i++) begin
      w_at_limit[i] = (r_cnt[i] == credits_lp);
      w_elig[i]     = req_v_i[i] & (r_cnt[i] < credits_lp);
      w_busy[i]     = (r_cnt[i] != '0);
    end
    for (int k = 0; k < num_req_p; k++) begin
      idx = (int'(r_rr_ptr) + k) % num_req_p;
      if (!w_found && w_elig[idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = lg_req_lp'(idx);
      end
    end
  end

  // A new request may load only when the issue register is empty or draining.
  // Gating with reset_n_i keeps the handshakes quiet while reset is held.
  assign w_grant = reset_n_i & alloc_v_i & (~r_issue_v | issue_ready_i) & w_found;

  always_comb begin
    req_ready_o = '0;
    if (w_grant) req_ready_o[w_gnt_idx] = 1'b1;
  end

  assign alloc_yumi_o = w_grant;

  // Return path: the owner table maps the in-order head back to its requester.
  assign resp_v_o   = deq_v_i;
  assign resp_src_o = r_owner[deq_id_i];
  assign deq_yumi_o = deq_v_i & resp_ready_i;

  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      w_inc[i] = w_grant & (w_gnt_idx == lg_req_lp'(i));
      w_dec[i] = deq_yumi_o & (resp_src_o == lg_req_lp'(i));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_req_p; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < num_req_p; i++) begin
        // Grant and return to the same requester cancel out.
        if (w_inc[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= lg_req_lp'((int'(w_gnt_idx) + 1) % num_req_p);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_issue_v   <= 1'b0;
      r_issue_id  <= '0;
      r_issue_src <= '0;
    end else if (w_grant) begin
      r_issue_v   <= 1'b1;
      r_issue_id  <= alloc_id_i;
      r_issue_src <= w_gnt_idx;
    end else if (issue_ready_i) begin
      r_issue_v   <= 1'b0;
    end
  end

  // NOTE: the owner table has no reset; an entry is always written at
  // allocation before the FIFO can present that ID for dequeue.
  always_ff @(posedge clk_i) begin
    if (w_grant) r_owner[alloc_id_i] <= w_gnt_idx;
  end

  assign issue_v_o   = r_issue_v;
  assign issue_id_o  = r_issue_id;
  assign issue_src_o = r_issue_src;
  assign idle_o      = ~(|w_busy) & ~r_issue_v;

`ifdef BSG_FIFO_REORDER_ISSUE_SCHED_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_credit_block_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_stall_cnt        <= '0;
      r_credit_block_cnt <= '0;
    end else begin
      if ((|req_v_i) && !w_grant && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if ((|(req_v_i & w_at_limit)) && (r_credit_block_cnt != '1))
        r_credit_block_cnt <= r_credit_block_cnt + 1'b1;
    end
  end

  assign stall_cnt_o        = r_stall_cnt;
  assign credit_block_cnt_o = r_credit_block_cnt;
`else
  logic w_unused_at_limit;
  assign w_unused_at_limit = |w_at_limit;
`endif

`ifndef BSG_HIDE_FROM_SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!deq_v_i || (r_cnt[resp_src_o] != '0))
        else $error("deq_v_i for an owner with no outstanding credit");
      assert ($onehot0(req_ready_o))
        else $error("req_ready_o is not one-hot-or-zero");
      for (int i = 0; i < num_req_p; i++) begin
        assert (r_cnt[i] <= credits_lp)
          else $error("credit counter above credits_p");
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_fifo_reorder_issue_sched.sv
module tb_bsg_fifo_reorder_issue_sched;

  localparam int num_req_p = 4;
  localparam int els_p     = 8;
  localparam int credits_p = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_v = '0;
  logic [3:0] req_ready;
  logic       alloc_v = 1'b0;
  logic [2:0] alloc_id = '0;
  logic       alloc_yumi;
  logic       issue_v;
  logic [2:0] issue_id;
  logic [1:0] issue_src;
  logic       issue_ready = 1'b0;
  logic       deq_v = 1'b0;
  logic [2:0] deq_id = '0;
  logic       deq_yumi;
  logic       resp_v;
  logic [1:0] resp_src;
  logic       resp_ready = 1'b0;
  logic       idle;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] exp_issue [$];  // {id, src}
  logic [1:0] exp_resp  [$];

  always #5 clk = ~clk;

  bsg_fifo_reorder_issue_sched #(
    .num_req_p(num_req_p),
    .els_p    (els_p),
    .credits_p(credits_p)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .req_v_i      (req_v),
    .req_ready_o  (req_ready),
    .alloc_v_i    (alloc_v),
    .alloc_id_i   (alloc_id),
    .alloc_yumi_o (alloc_yumi),
    .issue_v_o    (issue_v),
    .issue_id_o   (issue_id),
    .issue_src_o  (issue_src),
    .issue_ready_i(issue_ready),
    .deq_v_i      (deq_v),
    .deq_id_i     (deq_id),
    .deq_yumi_o   (deq_yumi),
    .resp_v_o     (resp_v),
    .resp_src_o   (resp_src),
    .resp_ready_i (resp_ready),
    .idle_o       (idle)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive after the edge, record expectations, check the
  // combinational handshakes at the falling edge.
  task automatic cyc(input logic [3:0] rv, input logic av, input logic [2:0] aid,
                     input logic ir, input logic dv, input logic [2:0] did,
                     input logic rr, input logic [3:0] exp_ready,
                     input logic [1:0] exp_src, input string tag);
    logic [1:0] g;
    @(posedge clk);
    #1;
    req_v = rv; alloc_v = av; alloc_id = aid; issue_ready = ir;
    deq_v = dv; deq_id = did; resp_ready = rr;
    if (exp_ready != 4'b0000) begin
      g = 2'd0;
      for (int i = 0; i < 4; i++) if (exp_ready[i]) g = 2'(i);
      exp_issue.push_back({aid, g});
    end
    if (dv && rr) exp_resp.push_back(exp_src);
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(req_ready), 32'(exp_ready));
    check({tag, "_alloc_yumi"}, 32'(alloc_yumi), 32'(exp_ready != 4'b0000));
    check({tag, "_deq_yumi"}, 32'(deq_yumi), 32'(dv & rr));
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT hands off.
  always @(negedge clk) begin
    if (rst_n) begin
      if (issue_v && issue_ready) begin
        check("issue_expected", 32'(exp_issue.size() != 0), 32'd1);
        if (exp_issue.size() != 0) begin
          logic [4:0] e;
          e = exp_issue.pop_front();
          check("issue_id", 32'(issue_id), 32'(e[4:2]));
          check("issue_src", 32'(issue_src), 32'(e[1:0]));
        end
      end
      if (resp_v && resp_ready) begin
        check("resp_expected", 32'(exp_resp.size() != 0), 32'd1);
        if (exp_resp.size() != 0) begin
          logic [1:0] s;
          s = exp_resp.pop_front();
          check("resp_src", 32'(resp_src), 32'(s));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with requests and a free ID offered during reset.
    req_v = 4'b1111; alloc_v = 1'b1;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_alloc_yumi", 32'(alloc_yumi), 32'd0);
    check("rst_issue_v", 32'(issue_v), 32'd0);
    check("rst_issue_id", 32'(issue_id), 32'd0);
    check("rst_issue_src", 32'(issue_src), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; req_v = '0; alloc_v = 1'b0;

    // Round-robin fairness: grants 0,1,2,3,0 on IDs 0..4.
    cyc(4'b1111, 1, 3'd0, 1, 0, 3'd0, 0, 4'b0001, 2'd0, "rr0");
    cyc(4'b1111, 1, 3'd1, 1, 0, 3'd0, 0, 4'b0010, 2'd0, "rr1");
    cyc(4'b1111, 1, 3'd2, 1, 0, 3'd0, 0, 4'b0100, 2'd0, "rr2");
    cyc(4'b1111, 1, 3'd3, 1, 0, 3'd0, 0, 4'b1000, 2'd0, "rr3");
    cyc(4'b1111, 1, 3'd4, 1, 0, 3'd0, 0, 4'b0001, 2'd0, "rr4");
    // In-order return of IDs 0..4, with one stalled response cycle.
    cyc(4'b0000, 0, 3'd0, 1, 1, 3'd0, 1, 4'b0000, 2'd0, "ret0");
    check("ret_busy", 32'(idle), 32'd0);
    cyc(4'b0000, 0, 3'd0, 1, 1, 3'd1, 0, 4'b0000, 2'd1, "ret_stall");
    cyc(4'b0000, 0, 3'd0, 1, 1, 3'd1, 1, 4'b0000, 2'd1, "ret1");
    cyc(4'b0000, 0, 3'd0, 1, 1, 3'd2, 1, 4'b0000, 2'd2, "ret2");
    cyc(4'b0000, 0, 3'd0, 1, 1, 3'd3, 1, 4'b0000, 2'd3, "ret3");
    cyc(4'b0000, 0, 3'd0, 1, 1, 3'd4, 1, 4'b0000, 2'd0, "ret4");
    cyc(4'b0000, 0, 3'd0, 1, 0, 3'd0, 0, 4'b0000, 2'd0, "ret_idle");
    check("ret_idle_o", 32'(idle), 32'd1);

    // Credit limit: requester 1 alone, two grants then blocked.
    cyc(4'b0010, 1, 3'd5, 1, 0, 3'd0, 0, 4'b0010, 2'd0, "cr0");
    cyc(4'b0010, 1, 3'd6, 1, 0, 3'd0, 0, 4'b0010, 2'd0, "cr1");
    cyc(4'b0010, 1, 3'd7, 1, 0, 3'd0, 0, 4'b0000, 2'd0, "cr_blk0");
    cyc(4'b0010, 1, 3'd7, 1, 0, 3'd0, 0, 4'b0000, 2'd0, "cr_blk1");
    cyc(4'b0010, 1, 3'd7, 1, 0, 3'd0, 0, 4'b0000, 2'd0, "cr_blk2");
    cyc(4'b0010, 1, 3'd7, 1, 1, 3'd5, 1, 4'b0000, 2'd1, "cr_ret");
    cyc(4'b0010, 1, 3'd7, 1, 0, 3'd0, 0, 4'b0010, 2'd0, "cr2");
    cyc(4'b0000, 0, 3'd0, 1, 1, 3'd6, 1, 4'b0000, 2'd1, "cr_drain0");
    cyc(4'b0000, 0, 3'd0, 1, 1, 3'd7, 1, 4'b0000, 2'd1, "cr_drain1");

    // Out-of-order ownership: ID0->2, ID1->0, ID2->3 (pointer starts at 2).
    cyc(4'b0100, 1, 3'd0, 1, 0, 3'd0, 0, 4'b0100, 2'd0, "ooo0");
    cyc(4'b0001, 1, 3'd1, 1, 0, 3'd0, 0, 4'b0001, 2'd0, "ooo1");
    cyc(4'b1000, 1, 3'd2, 1, 0, 3'd0, 0, 4'b1000, 2'd0, "ooo2");
    cyc(4'b0000, 0, 3'd0, 1, 1, 3'd0, 1, 4'b0000, 2'd2, "ooo_ret0");
    cyc(4'b0000, 0, 3'd0, 1, 1, 3'd1, 1, 4'b0000, 2'd0, "ooo_ret1");
    cyc(4'b0000, 0, 3'd0, 1, 1, 3'd2, 1, 4'b0000, 2'd3, "ooo_ret2");
    cyc(4'b0000, 0, 3'd0, 1, 0, 3'd0, 0, 4'b0000, 2'd0, "ooo_idle");
    check("ooo_idle_o", 32'(idle), 32'd1);

    // Downstream backpressure: issue held 5 cycles, no grants meanwhile.
    cyc(4'b0011, 1, 3'd3, 0, 0, 3'd0, 0, 4'b0001, 2'd0, "bp0");
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0011, 1, 3'd4, 0, 0, 3'd0, 0, 4'b0000, 2'd0, "bp_hold");
      check("bp_issue_v", 32'(issue_v), 32'd1);
      check("bp_issue_id", 32'(issue_id), 32'd3);
      check("bp_issue_src", 32'(issue_src), 32'd0);
    end
    cyc(4'b0011, 1, 3'd4, 1, 0, 3'd0, 0, 4'b0010, 2'd0, "bp_rel");
    cyc(4'b0000, 0, 3'd0, 1, 0, 3'd0, 0, 4'b0000, 2'd0, "bp_drain");
    check("bp_next_id", 32'(issue_id), 32'd4);
    check("bp_next_src", 32'(issue_src), 32'd1);

    // Simultaneous grant and return for requester 0 (count stays at 1).
    cyc(4'b0001, 1, 3'd5, 1, 1, 3'd3, 1, 4'b0001, 2'd0, "sim");
    cyc(4'b0001, 1, 3'd6, 1, 0, 3'd0, 0, 4'b0001, 2'd0, "sim_g");
    cyc(4'b0001, 1, 3'd7, 1, 0, 3'd0, 0, 4'b0000, 2'd0, "sim_blk");

    // Build counts {1,2,0,1} with an issue in flight, then reset mid-cycle.
    cyc(4'b0000, 0, 3'd0, 1, 1, 3'd4, 1, 4'b0000, 2'd1, "pre_ret0");
    cyc(4'b0000, 0, 3'd0, 1, 1, 3'd5, 1, 4'b0000, 2'd0, "pre_ret1");
    cyc(4'b1010, 1, 3'd7, 1, 0, 3'd0, 0, 4'b0010, 2'd0, "pre_g0");
    cyc(4'b1010, 1, 3'd0, 1, 0, 3'd0, 0, 4'b1000, 2'd0, "pre_g1");
    cyc(4'b0010, 1, 3'd1, 1, 0, 3'd0, 0, 4'b0010, 2'd0, "pre_g2");
    @(posedge clk);
    #1;
    req_v = '0; alloc_v = 1'b0; issue_ready = 1'b0; deq_v = 1'b0; resp_ready = 1'b0;
    #2;
    check("inflight_issue_v", 32'(issue_v), 32'd1);
    check("inflight_idle", 32'(idle), 32'd0);
    exp_issue.delete();
    req_v = 4'b1111; alloc_v = 1'b1; rst_n = 1'b0;
    #1;
    check("arst_issue_v", 32'(issue_v), 32'd0);
    check("arst_issue_id", 32'(issue_id), 32'd0);
    check("arst_idle", 32'(idle), 32'd1);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    check("arst_alloc_yumi", 32'(alloc_yumi), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; req_v = '0; alloc_v = 1'b0;
    #1;
    check("post_rst_idle", 32'(idle), 32'd1);
    cyc(4'b1111, 1, 3'd0, 1, 0, 3'd0, 0, 4'b0001, 2'd0, "post_rst_g");
    cyc(4'b0000, 0, 3'd0, 1, 1, 3'd0, 1, 4'b0000, 2'd0, "post_rst_ret");
    cyc(4'b0000, 0, 3'd0, 1, 0, 3'd0, 0, 4'b0000, 2'd0, "post_rst_idle");
    check("final_idle", 32'(idle), 32'd1);

    check("issue_queue_empty", 32'(exp_issue.size()), 32'd0);
    check("resp_queue_empty", 32'(exp_resp.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
